// File: rtl/seq_101.sv
// Mealy 1-0-1 serial pattern detector with a saturating detection counter.
// Define REG_OUT_EN to register det (one cycle later, glitch-free).
module seq_101 #(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp,
  output logic             det,
  output logic [CNT_W-1:0] det_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_1    = 2'b01,
    S_10   = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             in_one;
  logic             match;

  // Anything that is not a solid 1 (including X/Z) counts as a 0.
  assign in_one = (inp === 1'b1);
  assign match  = (state_reg == S_10) && in_one;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = S_IDLE;
    case (state_reg)
      S_IDLE: state_next = in_one ? S_1 : S_IDLE;
      S_1:    state_next = in_one ? S_1 : S_10;
      S_10: begin
        if (in_one) begin
          state_next = (OVERLAP != 0) ? S_1 : S_IDLE;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Counter holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (match && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign det_cnt = cnt_reg;

`ifdef REG_OUT_EN
  logic det_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_reg <= 1'b0;
    end else begin
      det_reg <= match;
    end
  end

  assign det = det_reg;
`else
  assign det = rst && match;
`endif

endmodule

// File: tb/tb_seq_101.sv
// Scoreboard bench for seq_101: overlapping, non-overlapping and 2-bit saturating instances
// share one stimulus stream; expectations are hand-computed per cycle.
module tb_seq_101;

  logic       clk;
  logic       rst;
  logic       inp;
  logic       det_ov;
  logic       det_nov;
  logic       det_sat;
  logic [7:0] cnt_ov;
  logic [7:0] cnt_nov;
  logic [1:0] cnt_sat;

  seq_101 #(.OVERLAP(1), .CNT_W(8)) dut_ov (
    .clk(clk), .rst(rst), .inp(inp), .det(det_ov), .det_cnt(cnt_ov)
  );
  seq_101 #(.OVERLAP(0), .CNT_W(8)) dut_nov (
    .clk(clk), .rst(rst), .inp(inp), .det(det_nov), .det_cnt(cnt_nov)
  );
  seq_101 #(.OVERLAP(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .inp(inp), .det(det_sat), .det_cnt(cnt_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic r;     // rst level held across the cycle
    logic p;     // short async reset pulse inside the cycle
    logic i;     // input bit (may be X)
    logic dov;
    logic dnov;
    int   cov;
    int   cnov;
    int   csat;
  } vec_t;

  typedef struct {
    logic dov;
    logic dnov;
    int   cov;
    int   cnov;
    int   csat;
    int   idx;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_chk;
  int   n_pass;

  task automatic add(input logic r, input logic p, input logic i, input logic dov,
                     input logic dnov, input int cov, input int cnov, input int csat);
    vec_t v;
    v.r = r; v.p = p; v.i = i; v.dov = dov; v.dnov = dnov;
    v.cov = cov; v.cnov = cnov; v.csat = csat;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, act, req);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: every cycle, 3 ns after the driving edge, compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("det_ov",  e.idx, {31'd0, det_ov},  {31'd0, e.dov});
        chk("det_nov", e.idx, {31'd0, det_nov}, {31'd0, e.dnov});
        chk("cnt_ov",  e.idx, {24'd0, cnt_ov},  e.cov);
        chk("cnt_nov", e.idx, {24'd0, cnt_nov}, e.cnov);
        chk("cnt_sat", e.idx, {30'd0, cnt_sat}, e.csat);
        $display("vec %0d rst=%b inp=%b det_ov=%b det_nov=%b cnt_ov=%0d cnt_nov=%0d cnt_sat=%0d",
                 e.idx, rst, inp, det_ov, det_nov, cnt_ov, cnt_nov, cnt_sat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic prev_ov;
    logic prev_nov;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    inp = 1'b0;

    // Reset held with toggling input, then 1,1,1 after release
    add(0,0,1, 0,0, 0,0,0);
    add(0,0,0, 0,0, 0,0,0);
    add(1,0,1, 0,0, 0,0,0);
    add(1,0,1, 0,0, 0,0,0);
    add(1,0,1, 0,0, 0,0,0);
    // Reference stream 0,1,0,1,1,0,1,1,0,0,1,0,1,1,0 (+ trailing 0)
    add(0,0,0, 0,0, 0,0,0);
    add(1,0,0, 0,0, 0,0,0);
    add(1,0,1, 0,0, 0,0,0);
    add(1,0,0, 0,0, 0,0,0);
    add(1,0,1, 1,1, 0,0,0);
    add(1,0,1, 0,0, 1,1,1);
    add(1,0,0, 0,0, 1,1,1);
    add(1,0,1, 1,1, 1,1,1);
    add(1,0,1, 0,0, 2,2,2);
    add(1,0,0, 0,0, 2,2,2);
    add(1,0,0, 0,0, 2,2,2);
    add(1,0,1, 0,0, 2,2,2);
    add(1,0,0, 0,0, 2,2,2);
    add(1,0,1, 1,1, 2,2,2);
    add(1,0,1, 0,0, 3,3,3);
    add(1,0,0, 0,0, 3,3,3);
    add(1,0,0, 0,0, 3,3,3);
    // Overlap check 1,0,1,0,1 (+ trailing 0)
    add(0,0,0, 0,0, 0,0,0);
    add(1,0,1, 0,0, 0,0,0);
    add(1,0,0, 0,0, 0,0,0);
    add(1,0,1, 1,1, 0,0,0);
    add(1,0,0, 0,0, 1,1,1);
    add(1,0,1, 1,0, 1,1,1);
    add(1,0,0, 0,0, 2,1,2);
    // Async reset pulse mid-pattern, then 1,1,0,1
    add(0,0,0, 0,0, 0,0,0);
    add(1,0,1, 0,0, 0,0,0);
    add(1,0,0, 0,0, 0,0,0);
    add(1,1,1, 0,0, 0,0,0);
    add(1,0,1, 0,0, 0,0,0);
    add(1,0,1, 0,0, 0,0,0);
    add(1,0,0, 0,0, 0,0,0);
    add(1,0,1, 1,1, 0,0,0);
    add(1,0,0, 0,0, 1,1,1);
    // Saturation: five overlapping detections
    add(0,0,0, 0,0, 0,0,0);
    add(1,0,1, 0,0, 0,0,0);
    add(1,0,0, 0,0, 0,0,0);
    add(1,0,1, 1,1, 0,0,0);
    add(1,0,0, 0,0, 1,1,1);
    add(1,0,1, 1,0, 1,1,1);
    add(1,0,0, 0,0, 2,1,2);
    add(1,0,1, 1,1, 2,1,2);
    add(1,0,0, 0,0, 3,2,3);
    add(1,0,1, 1,0, 3,2,3);
    add(1,0,0, 0,0, 4,2,3);
    add(1,0,1, 1,1, 4,2,3);
    add(1,0,0, 0,0, 5,3,3);
    // X on the input is treated as 0
    add(0,0,0, 0,0, 0,0,0);
    add(1,0,1, 0,0, 0,0,0);
    add(1,0,0, 0,0, 0,0,0);
    add(1,0,1'bx, 0,0, 0,0,0);
    add(1,0,1, 0,0, 0,0,0);
    add(1,0,0, 0,0, 0,0,0);
    add(1,0,1, 1,1, 0,0,0);
    add(1,0,0, 0,0, 1,1,1);

    prev_ov = 1'b0;
    prev_nov = 1'b0;
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      rst = vecs[k].r;
      inp = vecs[k].i;
      if (vecs[k].p) rst = 1'b0;
      e.idx  = k;
      e.cov  = vecs[k].cov;
      e.cnov = vecs[k].cnov;
      e.csat = vecs[k].csat;
`ifdef REG_OUT_EN
      // Registered flag shows the previous cycle's match; resets clear it.
      if (!vecs[k].r || vecs[k].p) begin
        prev_ov = 1'b0;
        prev_nov = 1'b0;
      end
      e.dov  = prev_ov;
      e.dnov = prev_nov;
      prev_ov  = vecs[k].dov;
      prev_nov = vecs[k].dnov;
`else
      e.dov  = vecs[k].dov;
      e.dnov = vecs[k].dnov;
`endif
      exp_q.push_back(e);
      if (vecs[k].p) begin
        #4;
        rst = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    #5;
    chk("queue_drain", 0, exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
